// File: rtl/mult_div_unit.sv
// mult_div_unit
//   Iterative multiply/divide unit for the MIPS datapath. Executes MULT,
//   MULTU, DIV and DIVU over WIDTH+1 cycles and writes the HI/LO registers
//   that MFHI/MFLO read. The pipeline stalls while Busy is high.
//   WIDTH must be even and at least 4.
//
// Ports
//   clk           system clock, rising edge
//   reset         asynchronous reset, active low
//   Start         request pulse, sampled only while Busy=0
//   MDUOperation  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   A             multiplicand / dividend (rs)
//   B             multiplier / divisor (rt)
//   Busy          operation in progress
//   Done          one-cycle pulse, HI/LO valid in the same cycle
//   DivByZero     qualifies Done for a divide with B==0
//   HI            product upper half, or remainder
//   LO            product lower half, or quotient
//
// state  | meaning
// IDLE   | waiting for Start, HI/LO hold the last result
// CALC   | one multiply/divide iteration per edge, WIDTH edges
// FINISH | sign correction, HI/LO write, Done pulse

module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       MDUOperation,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Busy,
  output logic             Done,
  output logic             DivByZero,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t state, state_nxt;

  // Operand magnitude that stays fixed: |A| for multiply, |B| for divide.
  logic [WIDTH-1:0]   opnd;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, remaining dividend bits / quotient bits}.
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      count;
  logic               is_div;
  logic               div_zero;
  logic               neg_q;
  logic               neg_r;

  logic               accept;
  logic               calc_en;
  logic               finish_en;

  logic               signed_in;
  logic               div_in;
  logic               a_neg_in;
  logic               b_neg_in;
  logic [WIDTH-1:0]   a_mag_in;
  logic [WIDTH-1:0]   b_mag_in;
  logic               div_zero_in;

  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_step;
  logic [WIDTH:0]     div_rem_sh;
  logic [WIDTH:0]     div_diff;
  logic [2*WIDTH-1:0] div_step;
  logic [2*WIDTH-1:0] fin_prod;
  logic [WIDTH-1:0]   fin_hi;
  logic [WIDTH-1:0]   fin_lo;

  always_comb begin
    signed_in   = ~MDUOperation[0];
    div_in      = MDUOperation[1];
    a_neg_in    = signed_in & A[WIDTH-1];
    b_neg_in    = signed_in & B[WIDTH-1];
    a_mag_in    = a_neg_in ? -A : A;
    b_mag_in    = b_neg_in ? -B : B;
    div_zero_in = div_in & (B == '0);
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (Start) state_nxt = div_zero_in ? FINISH : CALC;
      end
      CALC: begin
        if (count == LAST) state_nxt = FINISH;
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    Busy      = (state != IDLE);
    accept    = (state == IDLE) & Start;
    calc_en   = (state == CALC);
    finish_en = (state == FINISH);
  end

  // One iteration of shift-add multiply and restoring divide
  always_comb begin
    // The add can carry out of the upper half; the carry becomes the new MSB
    // after the right shift.
    mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
    mul_step   = {mul_sum, acc[WIDTH-1:1]};
    // Shifted remainder needs one extra bit before the trial subtract.
    div_rem_sh = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff   = div_rem_sh - {1'b0, opnd};
    if (div_diff[WIDTH])
      div_step = {div_rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
    else
      div_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  end

  // Final sign correction
  always_comb begin
    fin_prod = neg_q ? -acc : acc;
    fin_hi   = fin_prod[2*WIDTH-1:WIDTH];
    fin_lo   = fin_prod[WIDTH-1:0];
    if (div_zero) begin
      fin_hi = acc[2*WIDTH-1:WIDTH];
      fin_lo = acc[WIDTH-1:0];
    end else if (is_div) begin
      fin_hi = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      fin_lo = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      opnd      <= '0;
      acc       <= '0;
      count     <= '0;
      is_div    <= 1'b0;
      div_zero  <= 1'b0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      HI        <= '0;
      LO        <= '0;
    end else begin
      Done      <= 1'b0;
      DivByZero <= 1'b0;
      if (accept) begin
        count    <= '0;
        is_div   <= div_in;
        div_zero <= div_zero_in;
        neg_q    <= a_neg_in ^ b_neg_in;
        neg_r    <= div_in & a_neg_in;
        if (div_zero_in) begin
          // Divide by zero returns the raw dividend in HI and all ones in LO.
          opnd <= b_mag_in;
          acc  <= {A, {WIDTH{1'b1}}};
        end else if (div_in) begin
          opnd <= b_mag_in;
          acc  <= {{WIDTH{1'b0}}, a_mag_in};
        end else begin
          opnd <= a_mag_in;
          acc  <= {{WIDTH{1'b0}}, b_mag_in};
        end
      end else if (calc_en) begin
        count <= count + CW'(1);
        acc   <= is_div ? div_step : mul_step;
      end else if (finish_en) begin
        Done      <= 1'b1;
        DivByZero <= div_zero;
        HI        <= fin_hi;
        LO        <= fin_lo;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
module tb_mult_div_unit;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          Start = 1'b0;
  logic [1:0]    MDUOperation = 2'b00;
  logic [W-1:0]  A = '0;
  logic [W-1:0]  B = '0;
  logic          Busy, Done, DivByZero;
  logic [W-1:0]  HI, LO;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .Start(Start), .MDUOperation(MDUOperation),
    .A(A), .B(B), .Busy(Busy), .Done(Done), .DivByZero(DivByZero),
    .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           lat;
    int           acc_cyc;
  } exp_t;

  exp_t         scb[$];
  int           n_chk = 0;
  int           n_pass = 0;
  int           cyc = 0;
  int           busy_cnt = 0;
  logic [W-1:0] last_hi = '0;
  logic [W-1:0] last_lo = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  // Reference: plain SV arithmetic, special cases handled before dividing.
  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    logic signed [63:0] sa64, sb64, sp;
    logic [63:0] up;
    logic signed [W-1:0] sa, sb;
    e.dbz = 1'b0;
    e.lat = W + 1;
    e.acc_cyc = 0;
    sa = a;
    sb = b;
    case (op)
      2'b00: begin
        sa64 = {{W{a[W-1]}}, a};
        sb64 = {{W{b[W-1]}}, b};
        sp = sa64 * sb64;
        {e.hi, e.lo} = sp;
      end
      2'b01: begin
        up = {32'b0, a} * {32'b0, b};
        {e.hi, e.lo} = up;
      end
      default: begin
        if (b == '0) begin
          e.dbz = 1'b1;
          e.lat = 1;
          e.hi  = a;
          e.lo  = '1;
        end else if (op == 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          e.hi = '0;
          e.lo = 32'h8000_0000;
        end else if (op == 2'b10) begin
          e.lo = sa / sb;
          e.hi = sa % sb;
        end else begin
          e.lo = a / b;
          e.hi = a % b;
        end
      end
    endcase
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard monitor
  always @(negedge clk) begin
    if (!reset) begin
      busy_cnt = 0;
    end else begin
      if (Busy) busy_cnt++;
      if (Done) begin
        if (scb.size() == 0) begin
          chk("spurious_done", {63'b0, Done}, 64'd0);
        end else begin
          exp_t e;
          e = scb.pop_front();
          chk("hi", {32'b0, HI}, {32'b0, e.hi});
          chk("lo", {32'b0, LO}, {32'b0, e.lo});
          chk("dbz", {63'b0, DivByZero}, {63'b0, e.dbz});
          chk("latency", 64'(cyc - e.acc_cyc), 64'(e.lat));
          chk("busy_cycles", 64'(busy_cnt), 64'(e.lat));
          last_hi = e.hi;
          last_lo = e.lo;
        end
        busy_cnt = 0;
      end else begin
        chk("dbz_idle", {63'b0, DivByZero}, 64'd0);
      end
    end
  end

  // Called at a negedge; waits for Busy low, drives for one edge, then scrambles inputs.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t e;
    int n = 0;
    while (Busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    e = model(op, a, b);
    e.acc_cyc = cyc + 1;
    scb.push_back(e);
    Start = 1'b1;
    MDUOperation = op;
    A = a;
    B = b;
    @(negedge clk);
    Start = 1'b0;
    MDUOperation = 2'($urandom);
    A = $urandom;
    B = $urandom;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (scb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 64'(scb.size()), 64'd0);
    scb.delete();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #23;
    chk("rst_busy", {63'b0, Busy}, 64'd0);
    chk("rst_done", {63'b0, Done}, 64'd0);
    chk("rst_hilo", {HI, LO}, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_hilo", {HI, LO}, 64'd0);

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done("multu_max");
    run_op(2'b00, 32'hFFFF_FFFD, 32'h0000_0007);
    wait_done("mult_neg");
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000);
    wait_done("mult_min");
    run_op(2'b11, 32'd100, 32'd7);
    wait_done("divu");
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done("div_neg");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_wrap");
    run_op(2'b11, 32'd5, 32'd0);
    wait_done("divu_zero");
    run_op(2'b11, 32'd100, 32'd7);
    wait_done("after_zero");

    // Start while busy is ignored; HI/LO keep the previous result meanwhile.
    run_op(2'b01, 32'd3, 32'd4);
    repeat (4) @(negedge clk);
    Start = 1'b1;
    MDUOperation = 2'b11;
    A = 32'd9;
    B = 32'd3;
    @(negedge clk);
    Start = 1'b0;
    chk("hold_hi", {32'b0, HI}, {32'b0, last_hi});
    chk("hold_lo", {32'b0, LO}, {32'b0, last_lo});
    n = 0;
    while (!Done && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", {63'b0, Done}, 64'd1);
    run_op(2'b11, 32'd9, 32'd3);
    wait_done("back_to_back");

    // Reset in the middle of an operation
    run_op(2'b01, 32'd6, 32'd7);
    wait_done("multu_6x7");
    run_op(2'b01, 32'h0001_0000, 32'h0001_0000);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("midrst_busy", {63'b0, Busy}, 64'd0);
    chk("midrst_done", {63'b0, Done}, 64'd0);
    chk("midrst_hilo", {HI, LO}, 64'd0);
    scb.delete();
    last_hi = '0;
    last_lo = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    chk("no_done_after_rst", {HI, LO}, 64'd0);
    run_op(2'b10, 32'h7FFF_FFFF, 32'h0000_0010);
    wait_done("div_after_rst");

    for (int i = 0; i < 12; i++) begin
      logic [W-1:0] rb;
      rb = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
      run_op(2'($urandom), W'($urandom), rb);
      wait_done("random");
    end

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Sequential multiply/divide unit for the MIPS datapath. It is the iterative counterpart of the single-cycle ALU: the ALU handles add/sub/logic/shift in one cycle, and this block handles MULT, MULTU, DIV and DIVU over multiple cycles.
- Results go to dedicated HI/LO registers, which MFHI/MFLO read.
- The control unit stalls the pipeline while Busy is high.

Parameters:
- WIDTH, 32, operand and HI/LO width; also the iteration count. Must be even and at least 4.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- Start  input  1  request pulse; sampled only when Busy=0
- MDUOperation  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- A  input  WIDTH  rs operand: multiplicand or dividend
- B  input  WIDTH  rt operand: multiplier or divisor
- Busy  output  1  operation in progress
- Done  output  1  one-cycle pulse; HI/LO valid in the same cycle
- DivByZero  output  1  qualifies Done for DIV/DIVU with B==0
- HI  output  WIDTH  product upper half, or remainder
- LO  output  WIDTH  product lower half, or quotient

Behaviour:
- Reset (async, reset=0): state IDLE; Busy, Done, DivByZero, HI, LO and all internal registers go to 0 immediately. An operation in flight is discarded and HI/LO are not written.
- States: IDLE, CALC, FINISH.
- IDLE:
  - Rising edge with Start=1: latch operation and operands, count<=0, Busy<=1, go to CALC.
  - Signed ops (MULT, DIV) latch the absolute values of A and B and record the result signs.
  - DIV/DIVU with B==0: skip CALC and go directly to FINISH.
- CALC, one iteration per edge:
  - Multiply: shift-add, one multiplier bit per cycle, into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, one quotient bit per cycle.
  - count increments each edge; the edge completing iteration WIDTH moves to FINISH.
- FINISH, single edge:
  - Apply sign correction and write HI/LO. Busy<=0, Done<=1, go to IDLE.
  - Done and DivByZero are high for exactly one cycle.
- Latency (acceptance edge = edge 0):
  - Normal: Done high after edge WIDTH+1 (edge 33 for WIDTH=32); Busy high for WIDTH+1 cycles.
  - Divide-by-zero: Done high after edge 1.
- Back-to-back: Start during the Done cycle (Busy=0) is accepted at the next edge.
- Start while Busy=1 is ignored: operands and operation are not re-latched and no error is raised.
- Operand changes on A/B/MDUOperation after acceptance have no effect.
- Signed multiply: 2*WIDTH-bit product negated if sign(A) xor sign(B); HI = upper half, LO = lower half.
- Signed divide:
  - Quotient sign = sign(A) xor sign(B); remainder takes the sign of A (truncating division).
  - The most-negative dividend divided by -1 wraps: LO = 0x80000000, HI = 0.
- Unsigned ops: no sign handling.
- Divide by zero: HI <= A, LO <= all ones, DivByZero=1 with Done.
- HI/LO hold their values until the next FINISH or reset. They are never cleared by Start, so MFHI/MFLO reads during Busy return the previous result.

Test Plan:
- MULTU A=0xFFFFFFFF B=0xFFFFFFFF -> Done at cycle 33 after acceptance, HI=0xFFFFFFFE, LO=0x00000001, Busy high for 33 cycles.
- MULT A=0xFFFFFFFD(-3) B=0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB(-21). Then MULT 0x80000000 x 0x80000000 -> HI=0x40000000, LO=0.
- DIVU 100/7 -> LO=0x0000000E, HI=0x00000002. DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU A=5 B=0 -> Done one cycle after acceptance, DivByZero=1, HI=0x00000005, LO=0xFFFFFFFF. The following normal op shows DivByZero=0.
- MULTU 3x4 accepted, then Start with DIVU 9/3 pulsed at cycle 5 -> ignored, result HI=0, LO=12. Start in the Done cycle with DIVU 9/3 -> accepted, LO=3, HI=0.
- Complete MULTU 6x7 (HI=0, LO=42), then start MULTU 0x10000x0x10000 and assert reset at iteration 10 -> Busy/Done/HI/LO=0 asynchronously with no Done pulse. After release, DIV 0x7FFFFFFF/0x10 -> LO=0x07FFFFFF, HI=0xF.
